pc_trace_buffer: RTL and testbench

//   Hardware program-counter trace capture for the core. It sits beside the top-level core,

---
 rtl/pc_trace_buffer.sv | 135 +++++++++++++
 tb/tb_pc_trace_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_buffer.sv
// Retiring-PC trace capture: circular buffer that stops a programmable number
// of retires after a trigger PC, then drains oldest-first over valid/ready.
module pc_trace_buffer #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 16,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic [PC_WIDTH-1:0] trig_pc,
  input  logic [PTR_W:0]      post_cnt,
  input  logic                pc_valid,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [PC_WIDTH-1:0] rd_data,
  output logic                rd_last,
  output logic                busy,
  output logic                triggered,
  output logic [PTR_W:0]      fill
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FILL_MAX  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] POST_MAX  = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      fill_q, fill_d;
  logic [PTR_W:0]      rem_q, rem_d;
  logic                trig_q, trig_d;
  logic [PC_WIDTH-1:0] tpc_q, tpc_d;
  logic                mem_we;
  logic [PC_WIDTH-1:0] mem [DEPTH];

  // Next-state, pointer and counter logic for the capture/readout session.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    trig_d   = trig_q;
    tpc_d    = tpc_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          fill_d   = '0;
          trig_d   = 1'b0;
          tpc_d    = trig_pc;
          // Keeping at most DEPTH-1 post entries guarantees the trigger entry survives.
          rem_d    = (post_cnt > POST_MAX) ? POST_MAX : post_cnt;
        end
      end
      CAPTURE, POST: begin
        if (pc_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + CNT_ONE;
          if (state_q == CAPTURE) begin
            if (pc == tpc_q) begin
              trig_d  = 1'b1;
              state_d = (rem_q == '0) ? READOUT : POST;
            end
          end else begin
            rem_d = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) state_d = READOUT;
          end
        end
      end
      READOUT: begin
        if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          fill_d   = fill_q - CNT_ONE;
          if (fill_q == CNT_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Point at the oldest entry on the entering edge so the first READOUT
    // cycle already presents valid data; uses post-write pointer and fill.
    if (state_q != READOUT && state_d == READOUT)
      rd_ptr_d = wr_ptr_d - fill_d[PTR_W-1:0];
  end

  // Session state register with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      rem_q    <= '0;
      trig_q   <= 1'b0;
      tpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      rem_q    <= rem_d;
      trig_q   <= trig_d;
      tpc_q    <= tpc_d;
    end
  end

  // Trace storage write port; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= pc;
  end

  // Readout and status outputs.
  always_comb begin
    rd_valid  = (state_q == READOUT);
    rd_data   = rd_valid ? mem[rd_ptr_q] : '0;
    rd_last   = rd_valid && (fill_q == CNT_ONE);
    busy      = (state_q != IDLE);
    triggered = trig_q;
    fill      = fill_q;
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer with a queue-based reference model.
module tb_pc_trace_buffer;

  localparam int unsigned PCW   = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             arm;
  logic [PCW-1:0]   trig_pc;
  logic [PTR_W:0]   post_cnt;
  logic             pc_valid;
  logic [PCW-1:0]   pc;
  logic             rd_valid;
  logic             rd_ready;
  logic [PCW-1:0]   rd_data;
  logic             rd_last;
  logic             busy;
  logic             triggered;
  logic [PTR_W:0]   fill;

  int checks   = 0;
  int failures = 0;

  pc_trace_buffer #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .trig_pc(trig_pc),
    .post_cnt(post_cnt), .pc_valid(pc_valid), .pc(pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .triggered(triggered), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the window is a queue of the last DEPTH recorded PCs.
  int           m_ph = 0;   // 0 idle, 1 waiting for trigger, 2 post-trigger, 3 draining
  logic [31:0]  m_q[$];
  bit           m_trig = 1'b0;
  logic [31:0]  m_tpc;
  int           m_rem;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0;
      m_q.delete();
      m_trig = 1'b0;
    end else begin
      case (m_ph)
        0: if (arm) begin
          m_ph = 1;
          m_q.delete();
          m_trig = 1'b0;
          m_tpc = trig_pc;
          m_rem = (int'(post_cnt) > DEPTH - 1) ? DEPTH - 1 : int'(post_cnt);
        end
        1, 2: if (pc_valid) begin
          m_q.push_back(pc);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          if (m_ph == 1) begin
            if (pc == m_tpc) begin
              m_trig = 1'b1;
              m_ph = (m_rem == 0) ? 3 : 2;
            end
          end else begin
            m_rem--;
            if (m_rem == 0) m_ph = 3;
          end
        end
        3: if (rd_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_ph = 0;
        end
        default: m_ph = 0;
      endcase
    end
  end

  logic [31:0] got_q[$];
  bit          last_q[$];

  // Per-cycle comparison against the model, plus beat recording.
  always @(negedge clk) begin
    chk("busy", busy, 32'(m_ph != 0));
    chk("triggered", triggered, 32'(m_trig));
    chk("fill", fill, 32'(m_q.size()));
    chk("rd_valid", rd_valid, 32'(m_ph == 3));
    chk("rd_data", rd_data, (m_ph == 3 && m_q.size() > 0) ? m_q[0] : 32'h0);
    chk("rd_last", rd_last, 32'(m_ph == 3 && m_q.size() == 1));
    if (rd_valid && rd_ready) begin
      got_q.push_back(rd_data);
      last_q.push_back(rd_last);
    end
  end

  task automatic run_session(input string tag, input logic [31:0] trig, input logic [PTR_W:0] post,
                             input bit slow_ready, input bit gaps, input bit extra_arm,
                             input int exp_n, input logic [31:0] exp_first);
    int p;
    bit done;
    int nlast;
    got_q.delete();
    last_q.delete();
    arm = 1'b1; trig_pc = trig; post_cnt = post; pc_valid = 1'b0; rd_ready = 1'b0;
    step();
    arm = 1'b0;
    p = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      pc_valid = !(gaps && (c % 3 == 1));
      pc = 32'(p * 4);
      if (extra_arm && c == 2) begin
        arm = 1'b1; trig_pc = 32'h8; post_cnt = '0;
      end else begin
        arm = 1'b0;
      end
      rd_ready = slow_ready ? (c % 3 == 0) : 1'b1;
      step();
      if (pc_valid) p++;
      if (m_ph == 0) done = 1'b1;
    end
    pc_valid = 1'b0; rd_ready = 1'b0; arm = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_beats"}, 32'(got_q.size()), 32'(exp_n));
    nlast = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      chk({tag, "_seq"}, got_q[i], exp_first + 32'(4 * i));
      if (last_q[i]) nlast++;
    end
    chk({tag, "_nlast"}, 32'(nlast), 32'd1);
    if (last_q.size() > 0) chk({tag, "_lastpos"}, 32'(last_q[last_q.size()-1]), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_trig_end"}, 32'(triggered), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; trig_pc = '0; post_cnt = '0;
    pc_valid = 1'b0; pc = '0; rd_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);

    // Basic window: 0x00..0x18, 7 entries.
    run_session("basic", 32'h10, 4'd2, 1'b0, 1'b0, 1'b0, 7, 32'h00);
    // Wrap: full buffer, 0x30..0x4C.
    run_session("wrap", 32'h40, 4'd3, 1'b0, 1'b0, 1'b0, 8, 32'h30);
    // Clamp: largest encodable post count keeps the trigger entry first.
    run_session("clamp", 32'h10, 4'd15, 1'b0, 1'b0, 1'b0, 8, 32'h10);
    // Backpressure: ready one cycle in three.
    run_session("bp", 32'h40, 4'd3, 1'b1, 1'b0, 1'b0, 8, 32'h30);
    // Valid gaps plus a stray arm while capturing.
    run_session("gaps", 32'h10, 4'd2, 1'b0, 1'b1, 1'b1, 7, 32'h00);

    // Abort in READOUT.
    arm = 1'b1; trig_pc = 32'h10; post_cnt = 4'd2; step(); arm = 1'b0;
    begin
      int p = 0;
      for (int c = 0; c < 100 && m_ph != 3; c++) begin
        pc_valid = 1'b1; pc = 32'(p * 4); step(); p++;
      end
    end
    pc_valid = 1'b0;
    chk("abort_in_readout", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1; step();
    reset_n = 1'b0; #1;
    chk("abort_valid", 32'(rd_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fill", 32'(fill), 32'd0);
    chk("abort_data", rd_data, 32'h0);
    rd_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    run_session("rearm", 32'h10, 4'd2, 1'b0, 1'b0, 1'b0, 7, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
